booths_divider: RTL and testbench
=================================

# booths_divider

Sequential N-bit integer divider computing quotient and remainder with one restoring iteration per clock. It is the inverse companion to the team's sequential Booth multiplier and uses the same load/init/done handshake, so both blocks can share one arithmetic-unit controller. Signed two's-complement division is the default; an unsigned-only build is selectable at compile time.

## Interface
- N, default 32: operand, quotient and remainder width; legal values 4..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  start request; sampled only in IDLE.
- A  in  N  dividend; must be held stable from the load cycle through the cycle init rises.
- B  in  N  divisor; same stability rule as A.
- init  out  1  one-cycle pulse: operands captured.
- done  out  1  one-cycle pulse: Q, R, dbz valid.
- Q  out  N  quotient; held until the next done.
- R  out  N  remainder; held until the next done.
- dbz  out  1  divide-by-zero flag for the current result; held with Q and R.

## Operation
- States: IDLE, INIT, ITER, FIXUP, DONE.
- IDLE -> INIT when load=1; otherwise stay in IDLE.
- INIT:
  - Capture A and B; init<=1.
  - Compute operand magnitudes: in signed mode, negate negative operands; in unsigned mode, use raw values.
  - Latch sign_q = A[N-1]^B[N-1] and sign_r = A[N-1] (both 0 in unsigned mode).
  - Clear the N+1-bit partial remainder P; counter<=N-1.
  - If B==0, go to DONE; otherwise go to ITER.
- ITER, one cycle per quotient bit:
  - {P,D} <= {P,D}<<1.
  - Trial T = P_shifted − |B| (N+1 bits).
  - If T is non-negative, P<=T and D[0]<=1; otherwise restore, with D[0]<=0.
  - counter decrements; when counter==0 on this edge, go to FIXUP.
- FIXUP:
  - Quotient register <= sign_q ? −D : D.
  - Remainder register <= sign_r ? −P[N-1:0] : P[N-1:0].
  - Go to DONE.
- DONE:
  - Drive Q, R and dbz from the working registers; done<=1; go to IDLE.
- Result semantics: quotient truncates toward zero; the remainder has the sign of the dividend; A = Q·B + R holds.
- Divide by zero: Q = all ones, R = A unmodified, dbz=1.
- Signed overflow (A = −2^(N−1), B = −1): Q = −2^(N−1), R = 0, dbz=0. This is the natural result of the modulo-2^N negation; no special case is needed.
- Asserting load outside IDLE has no effect; there is no abort or queueing.

## Timing
- Reset values: state IDLE; init=0, done=0, dbz=0; Q=0, R=0; all internal registers 0.
- Reset mid-operation returns immediately to IDLE with all outputs zero; the in-flight result is discarded.
- Edge 0: load sampled high in IDLE.
- Edge 1: INIT actions execute; init is high for cycle 1→2.
- Normal latency: iterations run on edges 2..N+1, FIXUP on edge N+2, DONE on edge N+3. done is high for one cycle after edge N+3; Q, R and dbz update on that same edge.
- Divide-by-zero latency: DONE executes on edge 2, so done is high after edge 2.
- done and init are cleared by the first IDLE/ITER edge that follows them.
- Back-to-back operation: load held high during the done cycle is sampled in IDLE on the next edge, giving N+4 cycles per operation.
- Q and R change only on the DONE edge and on reset.

## Configuration
- SIGNED_DIV_EN, defined (default build): two's-complement signed operands, with sign correction in INIT and FIXUP as described.
- SIGNED_DIV_EN, undefined: A and B are unsigned. The negation logic is compiled out and sign_q and sign_r are constant 0. Divide by zero still returns Q = all ones and R = A. Latency is unchanged (FIXUP still occupies one cycle).

## Test plan
- N=32, signed, A=100, B=7 → after N+3 cycles: Q=14, R=2, dbz=0. init pulses once on edge 1; done pulses once.
- N=32, signed, A=−100, B=7 → Q=−14, R=−2. A=100, B=−7 → Q=−14, R=2. A=−100, B=−7 → Q=14, R=−2.
- N=8, signed, A=8'h80, B=8'hFF → Q=8'h80, R=0, dbz=0. In the unsigned build, the same operands give Q=0, R=8'h80.
- N=32, A=12345, B=0 → done after edge 2 with Q=32'hFFFFFFFF, R=12345, dbz=1. The next valid divide clears dbz.
- Operation with A=50, B=5 started; load pulsed again mid-ITER → ignored, result Q=10, R=0. A second run with load held high through done starts exactly one cycle after done.
- rst_n asserted at iteration 10 → all outputs 0 immediately. A fresh divide after release with A=−1, B=2 → Q=0, R=−1.

Source files
------------

// File: rtl/booths_divider.sv
// Sequential restoring divider: one quotient bit per clock, load/init/done handshake.
// Signed two's-complement when SIGNED_DIV_EN is defined; unsigned-only otherwise.
module booths_divider #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         init,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         dbz
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [2:0] {StIdle, StInit, StIter, StFixup, StDone} state_e;

  state_e          state_q;
  logic [N-1:0]    p_q;      // partial remainder, later the remainder result
  logic [N-1:0]    d_q;      // dividend shifting out, quotient shifting in
  logic [N-1:0]    b_mag_q;
  logic [CW-1:0]   cnt_q;
  logic            dbz_q;

  logic [N-1:0]    a_mag;
  logic [N-1:0]    b_mag;
  logic [N:0]      trial;

`ifdef SIGNED_DIV_EN
  logic            sign_q_q;
  logic            sign_r_q;

  assign a_mag = A[N-1] ? -A : A;
  assign b_mag = B[N-1] ? -B : B;
`else
  assign a_mag = A;
  assign b_mag = B;
`endif

  // P stays below |B| between iterations, so N bits of P plus the incoming bit suffice.
  assign trial = {p_q, d_q[N-1]} - {1'b0, b_mag_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      p_q      <= '0;
      d_q      <= '0;
      b_mag_q  <= '0;
      cnt_q    <= '0;
      dbz_q    <= 1'b0;
`ifdef SIGNED_DIV_EN
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
`endif
      init     <= 1'b0;
      done     <= 1'b0;
      Q        <= '0;
      R        <= '0;
      dbz      <= 1'b0;
    end else begin
      init <= 1'b0;
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load) state_q <= StInit;
        end
        StInit: begin
          init    <= 1'b1;
          b_mag_q <= b_mag;
          cnt_q   <= CW'(N - 1);
`ifdef SIGNED_DIV_EN
          sign_q_q <= A[N-1] ^ B[N-1];
          sign_r_q <= A[N-1];
`endif
          if (B == '0) begin
            // Divide by zero skips straight to DONE with the fixed result preloaded.
            dbz_q   <= 1'b1;
            d_q     <= '1;
            p_q     <= A;
            state_q <= StDone;
          end else begin
            dbz_q   <= 1'b0;
            d_q     <= a_mag;
            p_q     <= '0;
            state_q <= StIter;
          end
        end
        StIter: begin
          if (!trial[N]) begin
            p_q <= trial[N-1:0];
            d_q <= {d_q[N-2:0], 1'b1};
          end else begin
            p_q <= {p_q[N-2:0], d_q[N-1]};
            d_q <= {d_q[N-2:0], 1'b0};
          end
          if (cnt_q == '0) begin
            state_q <= StFixup;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFixup: begin
`ifdef SIGNED_DIV_EN
          if (sign_q_q) d_q <= -d_q;
          if (sign_r_q) p_q <= -p_q;
`endif
          state_q <= StDone;
        end
        StDone: begin
          Q       <= d_q;
          R       <= p_q;
          dbz     <= dbz_q;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_booths_divider.sv
// Bench for booths_divider: directed and random divides on N=32 and N=8 instances,
// checked against plain integer division; follows SIGNED_DIV_EN like the design.
module tb_booths_divider;

`ifdef SIGNED_DIV_EN
  localparam bit Signed = 1'b1;
`else
  localparam bit Signed = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        load32, init32, done32, dbz32;
  logic [31:0] a32, b32, q32, r32;
  logic        load8, init8, done8, dbz8;
  logic [7:0]  a8, b8, q8, r8;

  int compared   = 0;
  int mismatched = 0;

  booths_divider #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .load(load32), .A(a32), .B(b32),
    .init(init32), .done(done32), .Q(q32), .R(r32), .dbz(dbz32)
  );

  booths_divider #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .load(load8), .A(a8), .B(b8),
    .init(init8), .done(done8), .Q(q8), .R(r8), .dbz(dbz8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: truncating integer division on n-bit operands.
  function automatic void model(input int unsigned n, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] q, output logic [63:0] r, output logic z);
    logic [63:0] mask;
    longint      sa, sb;
    mask = (64'h1 << n) - 64'h1;
    z = (b == 64'h0);
    if (z) begin
      q = mask;
      r = a;
    end else if (Signed) begin
      sa = longint'(a << (64 - n)) >>> (64 - n);
      sb = longint'(b << (64 - n)) >>> (64 - n);
      q = 64'(sa / sb) & mask;
      r = 64'(sa % sb) & mask;
    end else begin
      q = (a / b) & mask;
      r = (a % b) & mask;
    end
  endfunction

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit mid_load);
    logic [63:0] eq, er;
    logic        ez;
    logic [31:0] q_prev, r_prev;
    int          lat, init_cnt, init_at;
    bit          held;
    model(32, {32'h0, a}, {32'h0, b}, eq, er, ez);
    @(negedge clk);
    a32 = a; b32 = b; load32 = 1'b1;
    q_prev = q32; r_prev = r32;
    @(posedge clk);
    #1 load32 = 1'b0;
    lat = -1; init_cnt = 0; init_at = -1; held = 1'b1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      if (mid_load) load32 = (c == 10);
      if (init32) begin init_cnt++; init_at = c; end
      if (done32) lat = c;
      else if (q32 !== q_prev || r32 !== r_prev) held = 1'b0;
    end
    load32 = 1'b0;
    check("latency", 64'(lat), ez ? 64'd2 : 64'd35);
    check("init_at", 64'(init_at), 64'd1);
    check("init_cnt", 64'(init_cnt), 64'd1);
    check("qr_held", 64'(held), 64'd1);
    check("q32", 64'(q32), eq);
    check("r32", 64'(r32), er);
    check("dbz32", 64'(dbz32), 64'(ez));
    @(posedge clk);
    #1 check("done_pulse", 64'(done32), 64'd0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    logic [63:0] eq, er;
    logic        ez;
    int          lat;
    model(8, {56'h0, a}, {56'h0, b}, eq, er, ez);
    @(negedge clk);
    a8 = a; b8 = b; load8 = 1'b1;
    @(posedge clk);
    #1 load8 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk);
      #1 if (done8) lat = c;
    end
    check("latency8", 64'(lat), ez ? 64'd2 : 64'd11);
    check("q8", 64'(q8), eq);
    check("r8", 64'(r8), er);
    check("dbz8", 64'(dbz8), 64'(ez));
  endtask

  initial begin
    int lat, gap;
    logic [31:0] ra, rb;
    logic [7:0]  sa8, sb8;
    rst_n = 1'b1;
    load32 = 1'b0; a32 = '0; b32 = '0;
    load8 = 1'b0; a8 = '0; b8 = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", 64'(q32), 64'd0);
    check("rst_r", 64'(r32), 64'd0);
    check("rst_flags", 64'({init32, done32, dbz32}), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    run32(32'd100, 32'd7, 1'b0);
    run32(-32'sd100, 32'd7, 1'b0);
    run32(32'd100, -32'sd7, 1'b0);
    run32(-32'sd100, -32'sd7, 1'b0);
    run8(8'h80, 8'hFF);
    run32(32'd12345, 32'd0, 1'b0);
    run32(32'd100, 32'd7, 1'b0);
    run32(32'd50, 32'd5, 1'b1);

    // Load held high through done: next init two edges after the done edge.
    @(negedge clk);
    a32 = 32'd50; b32 = 32'd5; load32 = 1'b1;
    lat = -1;
    for (int c = 0; c <= 40 && lat < 0; c++) begin
      @(posedge clk);
      #1 if (done32) lat = c;
    end
    check("b2b_lat", 64'(lat), 64'd35);
    gap = -1;
    for (int c = 1; c <= 5 && gap < 0; c++) begin
      @(posedge clk);
      #1 if (init32) gap = c;
    end
    load32 = 1'b0;
    check("b2b_gap", 64'(gap), 64'd2);
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk);
      #1 if (done32) lat = c;
    end
    check("b2b_lat2", 64'(lat), 64'd34);
    check("b2b_q", 64'(q32), 64'd10);
    check("b2b_r", 64'(r32), 64'd0);

    // Reset during iteration 10 discards the result and clears outputs at once.
    @(negedge clk);
    a32 = 32'd50; b32 = 32'd5; load32 = 1'b1;
    @(posedge clk);
    #1 load32 = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_q", 64'(q32), 64'd0);
    check("midrst_r", 64'(r32), 64'd0);
    check("midrst_flags", 64'({init32, done32, dbz32}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    run32(32'hFFFF_FFFF, 32'd2, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      run32(ra, rb, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      sa8 = 8'($urandom);
      sb8 = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      run8(sa8, sb8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
